btn_event_gen: RTL
==================

// Module: btn_event_gen
// PURPOSE
//  Consumes the debounced push-button level from the debounce stage and turns it
//  into clk-domain events for the micro-controller: one-cycle press/release pulses,
//  a long-press flag, and auto-repeat step pulses while held, plus a wrapping press
//  counter. Resynchronises the input, since the debounce output is launched from a divided clock.
// PARAMETERS
//  LONG_TICKS    25_000_000  clk cycles held before long-press (0.5 s @ 50 MHz); legal >= 2
//  REPEAT_TICKS  5_000_000   clk cycles between auto-repeat pulses in HELD; legal >= 2
//  CNT_W         8           width of press_cnt
// PORTS
//  clk            in   1      system clock, all logic on rising edge
//  rst            in   1      asynchronous, active-high reset
//  button_db      in   1      debounced button level, 1 = pressed
//  clr_cnt        in   1      synchronous clear of press_cnt
//  press_pulse    out  1      one-cycle pulse on press
//  release_pulse  out  1      one-cycle pulse on release
//  repeat_pulse   out  1      one-cycle pulse on long-press entry and each repeat
//  step           out  1      press_pulse | repeat_pulse (registered, same cycle)
//  long_press     out  1      level: high while in HELD
//  press_cnt      out  CNT_W  number of presses, modulo 2^CNT_W
// BEHAVIOUR
//  - Reset: all outputs 0, FSM = IDLE, sync flops 0, hold/repeat counters 0.
//  - Sync: button_db -> s1 -> s2 (two flops). FSM sees s2 only.
//  - Latency: button_db high before edge E1 -> s2 high after E2 -> press_pulse high
//    for exactly the cycle after edge E3. Release pulse has the same 3-edge latency.
//  - All outputs are registered. No combinational path from inputs to outputs.
//  - FSM states: IDLE, PRESSED, HELD.
//    IDLE:    s2=1 -> PRESSED, press_pulse=1, step=1, hold_cnt=0.
//    PRESSED: s2=0 -> IDLE, release_pulse=1.
//             else hold_cnt++. On the cycle hold_cnt==LONG_TICKS-1 -> HELD,
//             long_press=1, repeat_pulse=1, step=1, rpt_cnt=0.
//    HELD:    s2=0 -> IDLE, release_pulse=1, long_press=0 in the same edge.
//             else rpt_cnt++. On the cycle rpt_cnt==REPEAT_TICKS-1 -> repeat_pulse=1,
//             step=1, rpt_cnt=0.
//  - Release takes priority over long-press or repeat expiry on the same cycle.
//    No repeat_pulse is emitted with release_pulse.
//  - press_cnt: +1 on each press_pulse edge; wraps 2^CNT_W-1 -> 0.
//    Repeats and long-press do not count.
//    clr_cnt alone -> 0.
//    clr_cnt together with a press event -> 1 (clear, then count).
//  - hold_cnt and rpt_cnt are 32 bits, saturate-free. Both are reset to 0 on every FSM
//    entry, so neither can overflow for legal parameters.
//  - A glitch on button_db shorter than 1 clk can be missed or seen as a 1-cycle
//    press. A 1-cycle high yields press_pulse then release_pulse 1 cycle later. Legal.
//  - rst asserted mid-hold: outputs drop to 0 asynchronously.
//    After release of rst with button still high: s2 rises within 2 edges and a fresh
//    press_pulse is generated, and press_cnt counts from 0.
// TESTING (bench uses LONG_TICKS=8, REPEAT_TICKS=4, CNT_W=4)
//  1 Reset: rst=1 with button_db=1 -> all outputs 0. Release rst ->
//    press_pulse 1 cycle at 3rd edge, press_cnt=1.
//  2 Short press: button_db high 5 cycles -> one press_pulse, one release_pulse,
//    long_press never high, repeat_pulse never high.
//  3 Long hold of 30 cycles:
//    - long_press rises 8 cycles after press_pulse, with repeat_pulse.
//    - Further repeat_pulse every 4 cycles.
//    - step count = 1 + 1 + floor(remaining/4).
//    - long_press falls with release_pulse.
//  4 Release on expiry cycle: drop button_db so s2=0 when hold_cnt==7 ->
//    release_pulse only, no repeat_pulse, long_press stays 0.
//  5 Counter: 16 short presses from 0 -> press_cnt wraps to 0.
//    clr_cnt asserted on the press_pulse edge -> press_cnt=1.
//  6 Reset mid-HELD: assert rst asynchronously between edges -> long_press,
//    press_cnt go 0 immediately. Deassert with button held -> new press_pulse.

Source files
------------

// File: rtl/btn_event_gen.sv
// Turns a debounced, slow-domain button level into clk-domain press/release/long-press/
// auto-repeat events and a wrapping press counter. All outputs are registered.
module btn_event_gen #(
  parameter int unsigned LONG_TICKS   = 25_000_000,
  parameter int unsigned REPEAT_TICKS = 5_000_000,
  parameter int          CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button_db,
  input  logic             clr_cnt,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             repeat_pulse,
  output logic             step,
  output logic             long_press,
  output logic [CNT_W-1:0] press_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_e;

  localparam logic [31:0] LONG_LAST   = 32'(LONG_TICKS - 1);
  localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_TICKS - 1);

  state_e           state_q, state_d;
  logic             s1_q, s2_q;
  logic [31:0]      hold_cnt_q, hold_cnt_d;
  logic [31:0]      rpt_cnt_q, rpt_cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;
  logic             step_q, step_d;
  logic             long_q, long_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Release is tested first in every held state so it wins over any expiry.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rpt_cnt_d  = rpt_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    repeat_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d    = PRESSED;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end
      PRESSED: begin
        if (!s2_q) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d   = HELD;
          repeat_d  = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
      HELD: begin
        if (!s2_q) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (rpt_cnt_q == REPEAT_LAST) begin
          repeat_d  = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    long_d = (state_d == HELD);
    step_d = press_d | repeat_d;
    cnt_d  = (clr_cnt ? '0 : cnt_q) + CNT_W'(press_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      hold_cnt_q <= '0;
      rpt_cnt_q  <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      repeat_q   <= 1'b0;
      step_q     <= 1'b0;
      long_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      s1_q       <= button_db;
      s2_q       <= s1_q;
      hold_cnt_q <= hold_cnt_d;
      rpt_cnt_q  <= rpt_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      repeat_q   <= repeat_d;
      step_q     <= step_d;
      long_q     <= long_d;
      cnt_q      <= cnt_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign step          = step_q;
  assign long_press    = long_q;
  assign press_cnt     = cnt_q;
  assign dbg_state     = state_q;

endmodule
